// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: stack-op codes, FSM states and
// the reset value of the stack pointer.
package mem_stage_pkg;

  localparam int DATA_W = 16;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_INT  = 3'd5;
  localparam logic [2:0] OP_RTI  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PUSH2 = 2'd1,
    ST_POP2  = 2'd2
  } state_t;

  // Top of the word-addressed stack, which grows downward.
  function automatic int unsigned sp_init_f(input int unsigned addr_w);
    return (32'd1 << addr_w) - 32'd1;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_data_ram.sv
// Data memory: 2^ADDR_W x 16-bit words, asynchronous read, synchronous write.
// Contents are never reset.
module data_ram #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [15:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [15:0]       rdata
);

  logic [15:0] mem_r [0:(1<<ADDR_W)-1];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory stage: loads/stores, PUSH/POP and the two-word CALL/RET/INT/RTI
// stack sequences, with stack-pointer management and registered results.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int              ADDR_W  = 11,
  parameter logic [ADDR_W-1:0] SP_INIT = ADDR_W'(sp_init_f(ADDR_W))
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              mem_to_reg_in,
  input  logic              reg_write_in,
  input  logic [2:0]        stack_op_in,
  input  logic [15:0]       alu_result_in,
  input  logic [15:0]       write_data_in,
  input  logic [2:0]        reg_dest_in,
  input  logic [31:0]       pc_in,
  input  logic [3:0]        ccr_in,
  output logic              stall_out,
  output logic [15:0]       wb_data_out,
  output logic [15:0]       alu_result_out,
  output logic [2:0]        reg_dest_out,
  output logic              reg_write_out,
  output logic              mem_to_reg_out,
  output logic              pc_load_out,
  output logic [31:0]       pc_target_out,
  output logic              ccr_restore_out,
  output logic [3:0]        ccr_saved_out,
  output logic [ADDR_W-1:0] sp_out
);

  state_t            state_r;
  logic [ADDR_W-1:0] sp_r;
  logic [15:0]       low_r;
  logic              is_rti_r;

  logic [ADDR_W-1:0] sp_inc_s;
  logic [ADDR_W-1:0] sp_dec_s;
  logic [ADDR_W-1:0] addr_s;
  logic              two_word_s;
  logic              pass_grp_s;
  logic              we_s;
  logic              ram_we_s;
  logic [ADDR_W-1:0] waddr_s;
  logic [15:0]       wdata_s;
  logic [ADDR_W-1:0] raddr_s;
  logic [15:0]       rdata_s;

  assign sp_inc_s = sp_r + ADDR_W'(1);
  assign sp_dec_s = sp_r - ADDR_W'(1);
  assign addr_s   = alu_result_in[ADDR_W-1:0];

  assign two_word_s = (state_r == ST_IDLE) &&
                      ((stack_op_in == OP_CALL) || (stack_op_in == OP_RET) ||
                       (stack_op_in == OP_INT)  || (stack_op_in == OP_RTI));
  assign pass_grp_s = (state_r == ST_IDLE) && !two_word_s;
  assign stall_out  = two_word_s;
  assign sp_out     = sp_r;

  // Reset must also block a pending stack write so an aborted sequence leaves memory alone.
  assign ram_we_s = we_s & rst_n;

  // Memory port steering for the current state and op
  always_comb begin
    we_s    = 1'b0;
    waddr_s = sp_r;
    wdata_s = write_data_in;
    raddr_s = addr_s;
    case (state_r)
      ST_IDLE: begin
        case (stack_op_in)
          OP_PUSH: begin
            we_s = 1'b1;
          end
          OP_POP, OP_RET, OP_RTI: begin
            raddr_s = sp_inc_s;
          end
          OP_CALL, OP_INT: begin
            we_s    = 1'b1;
            wdata_s = pc_in[31:16];
          end
          default: begin
            we_s    = mem_write_in;
            waddr_s = addr_s;
          end
        endcase
      end
      ST_PUSH2: begin
        we_s    = 1'b1;
        wdata_s = low_r;
      end
      ST_POP2: begin
        raddr_s = sp_inc_s;
      end
      default: begin
        we_s = 1'b0;
      end
    endcase
  end

  data_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (waddr_s),
    .wdata (wdata_s),
    .raddr (raddr_s),
    .rdata (rdata_s)
  );

  // Register-write group: forwarded only for plain and single-word stack ops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_result_out <= 16'h0000;
      reg_dest_out   <= 3'd0;
      reg_write_out  <= 1'b0;
      mem_to_reg_out <= 1'b0;
    end else if (pass_grp_s) begin
      alu_result_out <= alu_result_in;
      reg_dest_out   <= reg_dest_in;
      reg_write_out  <= reg_write_in;
      mem_to_reg_out <= mem_to_reg_in;
    end else begin
      alu_result_out <= 16'h0000;
      reg_dest_out   <= 3'd0;
      reg_write_out  <= 1'b0;
      mem_to_reg_out <= 1'b0;
    end
  end

  // Stack FSM, stack pointer and stack-related outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r         <= ST_IDLE;
      sp_r            <= SP_INIT;
      low_r           <= 16'h0000;
      is_rti_r        <= 1'b0;
      wb_data_out     <= 16'h0000;
      pc_load_out     <= 1'b0;
      pc_target_out   <= 32'h0000_0000;
      ccr_restore_out <= 1'b0;
      ccr_saved_out   <= 4'h0;
    end else begin
      pc_load_out     <= 1'b0;
      ccr_restore_out <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          case (stack_op_in)
            OP_PUSH: begin
              sp_r <= sp_dec_s;
            end
            OP_POP: begin
              sp_r        <= sp_inc_s;
              wb_data_out <= rdata_s;
            end
            OP_CALL, OP_INT: begin
              sp_r    <= sp_dec_s;
              low_r   <= pc_in[15:0];
              state_r <= ST_PUSH2;
              if (stack_op_in == OP_INT) begin
                ccr_saved_out <= ccr_in;
              end
            end
            OP_RET, OP_RTI: begin
              sp_r     <= sp_inc_s;
              low_r    <= rdata_s;
              is_rti_r <= (stack_op_in == OP_RTI);
              state_r  <= ST_POP2;
            end
            default: begin
              if (mem_read_in) begin
                wb_data_out <= rdata_s;
              end
            end
          endcase
        end
        ST_PUSH2: begin
          sp_r    <= sp_dec_s;
          state_r <= ST_IDLE;
        end
        ST_POP2: begin
          sp_r            <= sp_inc_s;
          pc_target_out   <= {rdata_s, low_r};
          pc_load_out     <= 1'b1;
          ccr_restore_out <= is_rti_r;
          state_r         <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Memory stage of the 16-bit pipeline. It sits directly downstream of the execute/memory buffer and consumes its registered control, ALU result, store data, PC and flags. It performs data-memory load/store, single-word PUSH/POP, and two-word CALL/RET/INT/RTI stack sequences with stack-pointer management. Results are registered toward the memory/writeback side, and a stall is raised for multi-cycle stack ops.

Parameters:
ADDR_W, 11, data-memory word-address width (2^ADDR_W x 16-bit words)
SP_INIT, 2^ADDR_W-1, stack pointer value after reset (stack grows downward)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset: synchronous, active-low
mem_read_in  in  1  load request
mem_write_in  in  1  store request
mem_to_reg_in  in  1  writeback selects memory data
reg_write_in  in  1  register-file write enable
stack_op_in  in  3  0 none, 1 PUSH, 2 POP, 3 CALL, 4 RET, 5 INT, 6 RTI, 7 reserved (treated as none)
alu_result_in  in  16  load/store address; bypass value
write_data_in  in  16  store/PUSH data
reg_dest_in  in  3  destination register
pc_in  in  32  return address pushed by CALL/INT
ccr_in  in  4  flags captured on INT
stall_out  out  1  hold upstream stages
wb_data_out  out  16  memory read data (LOAD/POP)
alu_result_out  out  16  registered alu_result_in
reg_dest_out  out  3  registered destination
reg_write_out  out  1  registered write enable
mem_to_reg_out  out  1  registered select
pc_load_out  out  1  one-cycle pulse: redirect PC (RET/RTI)
pc_target_out  out  32  popped return address
ccr_restore_out  out  1  one-cycle pulse on RTI completion
ccr_saved_out  out  4  flags frozen at INT
sp_out  out  ADDR_W  current stack pointer

Behaviour:
- Reset (rst_n=0 at edge): SP=SP_INIT; FSM=IDLE; all outputs 0 (sp_out=SP_INIT); saved flags 0; memory contents not reset. Reset mid-sequence aborts; words already written remain.
- Memory: asynchronous read, synchronous write; address = low ADDR_W bits. Write committed at edge is visible to the next cycle's read.
- Outputs registered: one-cycle latency from acceptance in IDLE.
- FSM IDLE, accept per stack_op_in:
  - none: LOAD -> wb_data_out=mem[addr]; STORE -> mem[addr]=write_data_in.
  - PUSH: mem[SP]=write_data_in; SP-=1.
  - POP: SP+=1; wb_data_out=mem[SP+1].
  - CALL/INT: mem[SP]=pc_in[31:16]; SP-=1; latch pc_in[15:0]; go PUSH2. INT also latches ccr_in into ccr_saved_out.
  - RET/RTI: SP+=1; latch mem[SP+1] as low word; go POP2.
  - stall_out=1 combinationally in IDLE when op is CALL/RET/INT/RTI, else 0.
- PUSH2: mem[SP]=latched low; SP-=1; go IDLE; stall_out=0.
- POP2: SP+=1; pc_target_out={mem[SP+1], latched low}; pc_load_out=1 next cycle; RTI also pulses ccr_restore_out; go IDLE; stall_out=0.
- Inputs are ignored in PUSH2/POP2. The register-write group outputs are 0 for CALL/RET/INT/RTI.
- Stack op plus mem_read/mem_write asserted together: stack op wins, mem request ignored.
- SP arithmetic is modulo 2^ADDR_W: POP at 2^ADDR_W-1 wraps to 0; PUSH at 0 wraps to max. No error flag.
- Nested INT overwrites ccr_saved_out (single level).

Decomposition:
- Package mem_stage_pkg holds the stack_op encoding constants, the FSM state enum (IDLE, PUSH2, POP2), and SP_INIT derivation.
- One sub-module, data_ram: parameterized by ADDR_W, 16-bit, one async read port and one sync write port. FSM and SP logic stay in mem_stage_ctrl.

Test Plan:
- Reset, then STORE addr 0x0010 data 0xBEEF, next cycle LOAD 0x0010 -> wb_data_out=0xBEEF one cycle after the load; sp_out=0x7FF throughout.
- PUSH 0x1234, PUSH 0x5678, POP, POP -> wb_data_out 0x5678 then 0x1234; SP 0x7FF->0x7FD->0x7FF.
- CALL pc_in=0x0001_0020 -> stall_out high one cycle; mem[0x7FF]=0x0001, mem[0x7FE]=0x0020; SP=0x7FD. Then RET -> pc_load_out pulse with pc_target_out=0x0001_0020; SP=0x7FF.
- INT ccr_in=4'b1010, later RTI -> ccr_saved_out=1010; ccr_restore_out and pc_load_out pulse together; PC restored.
- POP at SP=0x7FF -> SP wraps to 0x000 and reads mem[0x000]; PUSH and mem_write same cycle -> only the stack write occurs.
- rst_n low during PUSH2 -> SP=0x7FF, FSM IDLE, stall_out 0, and no second word written.
